// File: rtl/noc_router_rr.sv
// noc_router_rr: 5-port (N,S,E,W,L) single-flit mesh router, XY routing.
//  - Per-input FIFO (FIFO_DEPTH entries). A write that arrives while the FIFO is full
//    is dropped and sets a sticky ovf_err bit.
//  - Per-output round-robin arbiter. The arbiter is gated by a saturating credit counter.
//  - out_data/out_valid/in_credit_o are registered. The minimum latency from in_valid
//    to out_valid is 2 cycles.
// Ports:
//  clk, rst (async, active low)
//  in_data[5*DATA_W], in_valid[5]           : flits in, port p at [p*DATA_W +: DATA_W]
//  in_credit_o[5]                           : pulse when a flit leaves input FIFO p
//  out_data[5*DATA_W], out_valid[5]         : flits out, same slicing
//  out_credit_i[5]                          : credit return from downstream
//  ovf_err[5]                               : sticky input overflow flags
//  stat_sel[3], stat_cnt[16]                : per-output flit counter readback
// Optional: define ROUTER_STATS_EN to build the per-output flit counters.
//           Without it, stat_cnt is tied to 0.

module noc_rr_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic [AW:0]       w_cnt;
  logic              w_full, w_wr_ok;
  logic              r_ovf;

  assign w_cnt   = r_wp - r_rp;
  assign w_full  = (w_cnt == (AW+1)'(DEPTH));
  assign o_empty = (w_cnt == '0);
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign w_wr_ok = i_wr & (~w_full | i_pop);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign o_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok)          r_wp  <= r_wp + 1'b1;
      if (i_pop)            r_rp  <= r_rp + 1'b1;
      if (i_wr && !w_wr_ok) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end
endmodule

module noc_router_rr #(
  parameter int DATA_W     = 16,
  parameter int COORD_W    = 4,
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_credit_o,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_credit_i,
  output logic [4:0]          ovf_err,
  input  logic [2:0]          stat_sel,
  output logic [15:0]         stat_cnt
);
  localparam int NP = 5;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [COORD_W-1:0] XC = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] YC = COORD_W'(YCOORD);

  logic [NP-1:0][DATA_W-1:0] w_in, w_head, w_gdata;
  logic [NP-1:0]             w_empty, w_pop, w_ovf, w_send;
  logic [NP-1:0][2:0]        w_route, w_nptr;
  logic [NP-1:0][NP-1:0]     w_req, w_gnt;   // [output][input]

  logic [NP-1:0][2:0]        r_ptr;
  logic [NP-1:0][CW-1:0]     r_cred;
  logic [NP-1:0][DATA_W-1:0] r_out_data;
  logic [NP-1:0]             r_out_valid, r_credit_o;

  // XY order: resolve X first, then Y. Equal in both dimensions means local.
  function automatic logic [2:0] route_of(input logic [DATA_W-1:0] f);
    logic [COORD_W-1:0] x, y;
    x = f[COORD_W-1:0];
    y = f[2*COORD_W-1:COORD_W];
    if (x > XC)      return 3'd2;
    else if (x < XC) return 3'd3;
    else if (y > YC) return 3'd0;
    else if (y < YC) return 3'd1;
    else             return 3'd4;
  endfunction

  // The first requester found when searching upward from ptr, wrapping mod 5.
  function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] req, input logic [2:0] ptr);
    logic [NP-1:0] g;
    logic          done;
    int            idx;
    g    = '0;
    done = 1'b0;
    for (int k = 0; k < NP; k++) begin
      idx = (int'(ptr) + k) % NP;
      if (!done && req[idx]) begin
        g[idx] = 1'b1;
        done   = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_in = in_data;

  for (genvar p = 0; p < NP; p++) begin : g_in
    noc_rr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (in_valid[p]),
      .i_wdata (w_in[p]),
      .i_pop   (w_pop[p]),
      .o_head  (w_head[p]),
      .o_empty (w_empty[p]),
      .o_ovf   (w_ovf[p])
    );
    assign w_route[p] = route_of(w_head[p]);
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    for (genvar i = 0; i < NP; i++) begin : g_req
      assign w_req[o][i] = ~w_empty[i] & (w_route[i] == 3'(o));
    end
    assign w_gnt[o]  = (r_cred[o] != '0) ? rr_pick(w_req[o], r_ptr[o]) : '0;
    assign w_send[o] = |w_gnt[o];
  end

  // Each input requests only one output, so at most one grant row hits any input.
  always_comb begin
    w_pop   = '0;
    w_gdata = '0;
    w_nptr  = r_ptr;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (w_gnt[o][i]) begin
          w_pop[i]   = 1'b1;
          w_gdata[o] = w_head[i];
          w_nptr[o]  = (i == NP-1) ? 3'd0 : 3'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_credit_o  <= '0;
      for (int o = 0; o < NP; o++) r_cred[o] <= CW'(CREDITS);
    end else begin
      r_out_valid <= w_send;
      r_credit_o  <= w_pop;
      for (int o = 0; o < NP; o++) begin
        if (w_send[o]) begin
          r_out_data[o] <= w_gdata[o];
          r_ptr[o]      <= w_nptr[o];
        end
        // A send and a returned credit in the same cycle cancel out.
        // A credit beyond CREDITS is ignored.
        case ({w_send[o], out_credit_i[o]})
          2'b10:   r_cred[o] <= r_cred[o] - 1'b1;
          2'b01:   if (r_cred[o] != CW'(CREDITS)) r_cred[o] <= r_cred[o] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign in_credit_o = r_credit_o;
  assign ovf_err     = w_ovf;

`ifdef ROUTER_STATS_EN
  logic [NP-1:0][15:0] r_stat;
  logic [15:0]         r_stat_cnt;

  // The counter advances on the grant edge, the same edge that raises out_valid.
  // The readback therefore shows the new count one cycle after that out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat     <= '0;
      r_stat_cnt <= '0;
    end else begin
      for (int o = 0; o < NP; o++)
        if (w_send[o] && r_stat[o] != 16'hFFFF) r_stat[o] <= r_stat[o] + 16'd1;
      r_stat_cnt <= (stat_sel < 3'd5) ? r_stat[stat_sel] : 16'd0;
    end
  end
  assign stat_cnt = r_stat_cnt;
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_noc_router_rr.sv
// Self-checking bench for noc_router_rr (XCOORD=1, YCOORD=1, 16-bit flits, depth 4, 4 credits).
// Flit layout used throughout: {tag[7:0], dstY[3:0], dstX[3:0]}.
module tb_noc_router_rr;
  localparam int DW = 16;
`ifdef ROUTER_STATS_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [5*DW-1:0] in_data, out_data;
  logic [4:0]    in_valid, in_credit_o, out_valid, out_credit_i, ovf_err;
  logic [2:0]    stat_sel;
  logic [15:0]   stat_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_router_rr #(.DATA_W(16), .COORD_W(4), .XCOORD(1), .YCOORD(1),
                  .FIFO_DEPTH(4), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_credit_o(in_credit_o), .out_data(out_data), .out_valid(out_valid),
    .out_credit_i(out_credit_i), .ovf_err(ovf_err), .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mkf(input logic [7:0] tag, input logic [3:0] x, input logic [3:0] y);
    return {tag, y, x};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(); in_valid = '0; out_credit_i = '0; endtask
  task automatic put(input int p, input logic [15:0] f);
    in_valid[p] = 1'b1;
    in_data[p*DW +: DW] = f;
  endtask
  task automatic do_reset(); idle(); rst = 1'b0; tick(); tick(); rst = 1'b1; endtask

  task automatic count_out(input int o, input int n, output int cnt, output logic [15:0] last);
    cnt = 0; last = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (out_valid[o]) begin cnt++; last = out_data[o*DW +: DW]; end
    end
  endtask

  // ---------------- reference model: queues + counters from the routing rules ----------------
  logic [15:0]      mq [5][$];
  int               mcred [5];
  int               mptr [5];
  logic [4:0]       movf, mvalid, mcr;
  logic [4:0][15:0] mdata;

  function automatic int route(input logic [15:0] f);
    int x, y;
    x = int'(f[3:0]); y = int'(f[7:4]);
    if (x > 1) return 2;
    if (x < 1) return 3;
    if (y > 1) return 0;
    if (y < 1) return 1;
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin mq[i].delete(); mcred[i] = 4; mptr[i] = 0; end
    movf = '0; mvalid = '0; mcr = '0; mdata = '0;
  endtask

  task automatic model_step();
    logic [4:0] popped;
    popped = '0; mvalid = '0;
    for (int o = 0; o < 5; o++) begin
      if (mcred[o] > 0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (mptr[o] + k) % 5;
          if (!found && mq[i].size() > 0 && route(mq[i][0]) == o) begin
            found = 1'b1; mvalid[o] = 1'b1; mdata[o] = mq[i][0];
            popped[i] = 1'b1; mptr[o] = (i + 1) % 5;
          end
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      int sz;
      sz = mq[i].size();
      if (popped[i]) void'(mq[i].pop_front());
      if (in_valid[i]) begin
        if (sz < 4 || popped[i]) mq[i].push_back(in_data[i*DW +: DW]);
        else movf[i] = 1'b1;
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (mvalid[o] && !out_credit_i[o]) mcred[o]--;
      else if (!mvalid[o] && out_credit_i[o] && mcred[o] < 4) mcred[o]++;
    end
    mcr = popped;
  endtask

  typedef struct { logic [3:0] x; logic [3:0] y; int port; } vec_t;
  vec_t vt[8];
  int   ord[4];

  initial begin
    int          cnt, c2;
    logic [15:0] last;
    logic [4:0]  seen;

    vt[0] = '{4'd2,  4'd1,  2};  vt[1] = '{4'd0, 4'd1,  3};
    vt[2] = '{4'd1,  4'd2,  0};  vt[3] = '{4'd1, 4'd0,  1};
    vt[4] = '{4'd1,  4'd1,  4};  vt[5] = '{4'd15, 4'd0, 2};
    vt[6] = '{4'd1,  4'd15, 0};  vt[7] = '{4'd0, 4'd15, 3};
    ord[0] = 0; ord[1] = 1; ord[2] = 3; ord[3] = 4;

    // reset state
    idle(); in_data = '0; stat_sel = 3'd0; rst = 1'b0;
    #12;
    chk("rst_valid",  80'(out_valid),   80'(0));
    chk("rst_credit", 80'(in_credit_o), 80'(0));
    chk("rst_ovf",    80'(ovf_err),     80'(0));
    chk("rst_data",   out_data,         80'(0));
    chk("rst_stat",   80'(stat_cnt),    80'(0));
    tick(); rst = 1'b1;

    // routing table: flits from L, one per cycle, 2-cycle latency
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) put(4, mkf(8'(8'hA0 + k), vt[k].x, vt[k].y)); else idle();
      tick();
      if (k == 0) chk("route_latency", 80'(out_valid), 80'(0));
      else begin
        chk("route_valid",  80'(out_valid), 80'(5'b00001 << vt[k-1].port));
        chk("route_data",   80'(out_data[vt[k-1].port*DW +: DW]),
            80'(mkf(8'(8'hA0 + k - 1), vt[k-1].x, vt[k-1].y)));
        chk("route_credit", 80'(in_credit_o), 80'(5'b10000));
      end
    end

    // contention on E. Credits are returned on every send, so the count must stay at 4.
    do_reset();
    out_credit_i = 5'b00100;
    put(0, mkf(8'hC0, 4'd2, 4'd1)); put(1, mkf(8'hC1, 4'd2, 4'd1));
    put(3, mkf(8'hC3, 4'd2, 4'd1)); put(4, mkf(8'hC4, 4'd2, 4'd1));
    tick(); in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_valid", 80'(out_valid), 80'(5'b00100));
      chk("cont_data",  80'(out_data[2*DW +: DW]), 80'(mkf(8'(8'hC0 + ord[k]), 4'd2, 4'd1)));
    end
    tick(); chk("cont_idle", 80'(out_valid), 80'(0));
    // ptr[E] must be back at 0, so N wins over L
    put(0, mkf(8'hD0, 4'd2, 4'd1)); put(4, mkf(8'hD4, 4'd2, 4'd1));
    tick(); in_valid = '0;
    tick(); chk("ptr_first",  80'(out_data[2*DW +: DW]), 80'(mkf(8'hD0, 4'd2, 4'd1)));
    tick(); chk("ptr_second", 80'(out_data[2*DW +: DW]), 80'(mkf(8'hD4, 4'd2, 4'd1)));
    out_credit_i = '0;

    // credits: 6 flits to E, only 4 go. Two credit pulses release the other 2.
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      put(4, mkf(8'(8'h60 + k), 4'd2, 4'd1)); tick();
      if (out_valid[2]) cnt++;
    end
    idle(); count_out(2, 6, c2, last);
    chk("credit_stall_cnt", 80'(cnt + c2), 80'(4));
    cnt = 0;
    out_credit_i[2] = 1'b1; tick(); if (out_valid[2]) cnt++;
    out_credit_i = '0;      tick(); if (out_valid[2]) cnt++;
    out_credit_i[2] = 1'b1; tick(); if (out_valid[2]) cnt++;
    out_credit_i = '0;
    count_out(2, 6, c2, last);
    chk("credit_resume_cnt",  80'(cnt + c2), 80'(2));
    chk("credit_resume_last", 80'(last), 80'(mkf(8'h65, 4'd2, 4'd1)));

    // overflow: E has no credits. The 5th write on W is dropped.
    do_reset();
    for (int k = 0; k < 4; k++) begin put(4, mkf(8'(8'h40 + k), 4'd2, 4'd1)); tick(); end
    idle(); tick(); tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin put(3, mkf(8'(8'h30 + k), 4'd2, 4'd1)); tick(); end
    idle();
    chk("ovf_w_set", 80'(ovf_err), 80'(5'b01000));
    for (int k = 0; k < 4; k++) begin put(0, mkf(8'(k), 4'd2, 4'd1)); tick(); end
    idle();
    chk("ovf_n_full", 80'(ovf_err), 80'(5'b01000));
    out_credit_i[2] = 1'b1; tick(); out_credit_i = '0;
    put(0, mkf(8'h04, 4'd2, 4'd1)); tick(); idle();    // write + pop on a full N FIFO
    chk("ovf_wrpop_valid", 80'(out_valid), 80'(5'b00100));
    chk("ovf_wrpop_data",  80'(out_data[2*DW +: DW]), 80'(mkf(8'h00, 4'd2, 4'd1)));
    chk("ovf_wrpop_noflag", 80'(ovf_err), 80'(5'b01000));
    tick(); tick(); tick();
    chk("ovf_sticky", 80'(ovf_err), 80'(5'b01000));
    rst = 1'b0; #1;
    chk("ovf_rst_clear", 80'(ovf_err), 80'(0));
    tick(); rst = 1'b1;

    // reset while traffic is in flight
    do_reset();
    put(0, mkf(8'h50, 4'd2, 4'd1)); put(1, mkf(8'h51, 4'd0, 4'd1));
    put(2, mkf(8'h52, 4'd1, 4'd2)); put(3, mkf(8'h53, 4'd1, 4'd0));
    tick();
    in_valid[2] = 1'b0;                                 // 3 more flits stay queued
    tick(); idle();
    chk("mid_pre_valid", 80'(out_valid), 80'(5'b01111));
    rst = 1'b0; #1;
    chk("mid_async_valid",  80'(out_valid),   80'(0));
    chk("mid_async_data",   out_data,         80'(0));
    chk("mid_async_credit", 80'(in_credit_o), 80'(0));
    tick(); tick(); rst = 1'b1;
    seen = '0;
    for (int k = 0; k < 6; k++) begin tick(); seen |= out_valid; end
    chk("mid_no_flits", 80'(seen), 80'(0));
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      put(4, mkf(8'(8'h80 + k), 4'd2, 4'd1)); tick();
      if (out_valid[2]) cnt++;
    end
    idle(); count_out(2, 6, c2, last);
    chk("mid_credits_4", 80'(cnt + c2), 80'(4));

    // stats readback
    do_reset(); stat_sel = 3'd0;
    for (int k = 0; k < 3; k++) begin put(4, mkf(8'(8'h70 + k), 4'd1, 4'd2)); tick(); end
    idle();
    tick();
    chk("stat_last_valid", 80'(out_valid), 80'(5'b00001));
    chk("stat_lag",        80'(stat_cnt),  80'(STAT_ON ? 2 : 0));
    tick(); chk("stat_n3",    80'(stat_cnt), 80'(STAT_ON ? 3 : 0));
    stat_sel = 3'd6; tick(); chk("stat_sel6", 80'(stat_cnt), 80'(0));
    stat_sel = 3'd2; tick(); chk("stat_sel2", 80'(stat_cnt), 80'(0));
    stat_sel = 3'd0; tick(); chk("stat_back", 80'(stat_cnt), 80'(STAT_ON ? 3 : 0));

    // randomized traffic against the queue model: a light phase, then a congested phase
    do_reset(); model_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc < 250) begin
        in_valid     = 5'($urandom) & 5'($urandom);
        out_credit_i = 5'($urandom) | 5'($urandom);
      end else begin
        in_valid     = 5'($urandom) | 5'($urandom);
        out_credit_i = 5'($urandom) & 5'($urandom);
      end
      for (int p = 0; p < 5; p++)
        in_data[p*DW +: DW] = {8'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      model_step();
      tick();
      chk("rnd_valid",  80'(out_valid),   80'(mvalid));
      chk("rnd_data",   out_data,         80'(mdata));
      chk("rnd_credit", 80'(in_credit_o), 80'(mcr));
      chk("rnd_ovf",    80'(ovf_err),     80'(movf));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
